// File: rtl/boid_frame_writer.sv
`default_nettype none
// ============================================================================
// boid_frame_writer: double-buffered display memory filler (clear + sprites).
// Rev 1.0 -- optional BOID_CLIP_EN suppresses off-screen sprite pixels.
// ============================================================================
module boid_frame_writer #(
  parameter int MAX_BOIDS           = 4,
  parameter int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS),
  parameter int VIDEO_WIDTH         = 640,
  parameter int VIDEO_HEIGHT        = 480,
  parameter int PIXEL_ADDRESS_WIDTH = 19,
  parameter int SPRITE_SIZE         = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           screen_end,
  output logic [BITS_FOR_BOIDS-1:0]      boid_sel,
  input  logic [9:0]                     boid_x,
  input  logic [8:0]                     boid_y,
  output logic                           wr_en,
  output logic                           wr_buf,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] wr_addr,
  output logic                           wr_data,
  output logic                           disp_buf,
  output logic                           busy,
  output logic                           frame_done,
  output logic [7:0]                     overrun_count
);

  localparam int                           PIXEL_COUNT = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam logic [PIXEL_ADDRESS_WIDTH-1:0] LAST_ADDR = PIXEL_ADDRESS_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [BITS_FOR_BOIDS-1:0]    LAST_BOID   = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  localparam logic [2:0]                   S_LAST      = 3'(SPRITE_SIZE - 1);
  localparam logic [9:0]                   W10         = 10'(VIDEO_WIDTH);
  localparam logic [8:0]                   H9          = 9'(VIDEO_HEIGHT);
  localparam logic [10:0]                  W11         = 11'(VIDEO_WIDTH);
  localparam logic [9:0]                   H10         = 10'(VIDEO_HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
    ST_DRAW  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t                           state_q;
  logic                             disp_buf_q, wr_en_q, wr_data_q, busy_q, frame_done_q;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   wr_addr_q;
  logic [BITS_FOR_BOIDS-1:0]        boid_sel_q;
  logic [7:0]                       overrun_q;
  logic [9:0]                       bx_q;
  logic [8:0]                       by_q;
  logic [2:0]                       dx_q, dy_q, dx_d, dy_d;
  logic                             last_pix;
  logic [PIXEL_ADDRESS_WIDTH:0]     pix_first, pix_next;

  // Returns {write_valid, address}; address = py*640 built from shifts.
  function automatic logic [PIXEL_ADDRESS_WIDTH:0] pix(input logic [9:0] bx, input logic [8:0] by,
                                                       input logic [2:0] dx, input logic [2:0] dy);
    logic [10:0]                    sx;
    logic [9:0]                     sy;
    logic [9:0]                     px;
    logic [8:0]                     py;
    logic                           ok;
    logic [PIXEL_ADDRESS_WIDTH-1:0] pyw;
    sx = {1'b0, bx} + {8'b0, dx};
    sy = {1'b0, by} + {7'b0, dy};
`ifdef BOID_CLIP_EN
    ok = (sx < W11) && (sy < H10);
    px = sx[9:0];
    py = sy[8:0];
`else
    ok = 1'b1;
    px = (sx >= W11) ? 10'(sx - W11) : sx[9:0];
    py = (sy >= H10) ? 9'(sy - H10) : sy[8:0];
`endif
    pyw = PIXEL_ADDRESS_WIDTH'(py);
    return {ok, (pyw << 9) + (pyw << 7) + PIXEL_ADDRESS_WIDTH'(px)};
  endfunction

  always_comb begin
    dx_d = dx_q + 3'd1;
    dy_d = dy_q;
    if (dx_q == S_LAST) begin
      dx_d = 3'd0;
      dy_d = dy_q + 3'd1;
    end
    last_pix  = (dx_q == S_LAST) && (dy_q == S_LAST);
    pix_next  = pix(bx_q, by_q, dx_d, dy_d);
    pix_first = pix(boid_x, boid_y, 3'd0, 3'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      disp_buf_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 1'b0;
      wr_addr_q    <= '0;
      boid_sel_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 8'd0;
      bx_q         <= 10'd0;
      by_q         <= 9'd0;
      dx_q         <= 3'd0;
      dy_q         <= 3'd0;
    end else begin
      // Any pulse outside IDLE, including the DONE cycle, is an overrun.
      if (state_q != ST_IDLE && screen_end && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;
      case (state_q)
        ST_IDLE: if (screen_end) begin
          disp_buf_q <= ~disp_buf_q;
          busy_q     <= 1'b1;
          wr_en_q    <= 1'b1;
          wr_data_q  <= 1'b0;
          wr_addr_q  <= '0;
          state_q    <= ST_CLEAR;
        end
        ST_CLEAR: if (wr_addr_q == LAST_ADDR) begin
          wr_en_q    <= 1'b0;
          boid_sel_q <= '0;
          state_q    <= ST_FETCH;
        end else begin
          wr_addr_q  <= wr_addr_q + PIXEL_ADDRESS_WIDTH'(1);
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_LATCH: begin
          bx_q <= boid_x;
          by_q <= boid_y;
          dx_q <= 3'd0;
          dy_q <= 3'd0;
          if (boid_x >= W10 || boid_y >= H9) begin
            state_q <= ST_NEXT;
          end else begin
            wr_en_q   <= pix_first[PIXEL_ADDRESS_WIDTH];
            wr_data_q <= 1'b1;
            wr_addr_q <= pix_first[PIXEL_ADDRESS_WIDTH-1:0];
            state_q   <= ST_DRAW;
          end
        end
        ST_DRAW: if (last_pix) begin
          wr_en_q <= 1'b0;
          state_q <= ST_NEXT;
        end else begin
          dx_q      <= dx_d;
          dy_q      <= dy_d;
          wr_en_q   <= pix_next[PIXEL_ADDRESS_WIDTH];
          wr_addr_q <= pix_next[PIXEL_ADDRESS_WIDTH-1:0];
        end
        ST_NEXT: if (boid_sel_q == LAST_BOID) begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          boid_sel_q   <= '0;
          wr_data_q    <= 1'b0;
          state_q      <= ST_DONE;
        end else begin
          boid_sel_q   <= boid_sel_q + BITS_FOR_BOIDS'(1);
          state_q      <= ST_FETCH;
        end
        ST_DONE: begin
          frame_done_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign boid_sel      = boid_sel_q;
  assign wr_en         = wr_en_q;
  assign wr_buf        = ~disp_buf_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign disp_buf      = disp_buf_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overrun_count = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_boid_frame_writer.sv
`default_nettype none
// ============================================================================
// tb_boid_frame_writer: scoreboard bench for boid_frame_writer (12-line frame).
// Rev 1.0 -- expectations follow BOID_CLIP_EN when defined.
// ============================================================================
module tb_boid_frame_writer;
  localparam int MB  = 4;
  localparam int BFB = 2;
  localparam int VW  = 640;
  localparam int VH  = 12;
  localparam int PAW = 19;
  localparam int SS  = 2;
  localparam int PC  = VW * VH;

  logic           clock = 1'b0;
  logic           reset;
  logic           screen_end;
  logic [BFB-1:0] boid_sel;
  logic [9:0]     boid_x;
  logic [8:0]     boid_y;
  logic           wr_en, wr_buf, wr_data, disp_buf, busy, frame_done;
  logic [PAW-1:0] wr_addr;
  logic [7:0]     overrun_count;

  int             n_vec = 0;
  int             n_miss = 0;
  int             done_pulses = 0;
  bit             mon_en = 1'b0;
  logic [9:0]     xs [MB];
  logic [8:0]     ys [MB];
  logic [PAW:0]   exp_q [$];
  logic [BFB-1:0] sel_log [$];

  boid_frame_writer #(
    .MAX_BOIDS(MB), .BITS_FOR_BOIDS(BFB), .VIDEO_WIDTH(VW), .VIDEO_HEIGHT(VH),
    .PIXEL_ADDRESS_WIDTH(PAW), .SPRITE_SIZE(SS)
  ) dut (
    .clock(clock), .reset(reset), .screen_end(screen_end), .boid_sel(boid_sel),
    .boid_x(boid_x), .boid_y(boid_y), .wr_en(wr_en), .wr_buf(wr_buf),
    .wr_addr(wr_addr), .wr_data(wr_data), .disp_buf(disp_buf), .busy(busy),
    .frame_done(frame_done), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  // Position source with one cycle of read latency.
  always @(posedge clock) begin
    boid_x <= xs[boid_sel];
    boid_y <= ys[boid_sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    logic wb_exp;
    if (mon_en) begin
      if (busy && (sel_log.size() == 0 || boid_sel != sel_log[$])) sel_log.push_back(boid_sel);
      if (frame_done) done_pulses++;
      if (wr_en) begin
        wb_exp = ~disp_buf;
        check("wr_buf", {31'b0, wr_buf}, {31'b0, wb_exp});
        if (exp_q.size() == 0) check("wr_unexpected", exp_q.size(), 1);
        else check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  function automatic bit slot_valid(input int b);
    return (xs[b] < VW) && (ys[b] < VH);
  endfunction

  function automatic void push_frame();
    for (int a = 0; a < PC; a++) exp_q.push_back({PAW'(a), 1'b0});
    for (int b = 0; b < MB; b++) begin
      if (slot_valid(b)) begin
        for (int dy = 0; dy < SS; dy++) begin
          for (int dx = 0; dx < SS; dx++) begin
            int px = int'(xs[b]) + dx;
            int py = int'(ys[b]) + dy;
            bit ok = 1'b1;
`ifdef BOID_CLIP_EN
            if (px >= VW || py >= VH) ok = 1'b0;
`else
            if (px >= VW) px -= VW;
            if (py >= VH) py -= VH;
`endif
            if (ok) exp_q.push_back({PAW'(py * VW + px), 1'b1});
          end
        end
      end
    end
  endfunction

  function automatic int frame_edges();
    int n = PC;
    for (int b = 0; b < MB; b++) n += slot_valid(b) ? 3 + SS * SS : 3;
    return n;
  endfunction

  task automatic run_frame(input string tag, input logic exp_disp, input bit pulse_clear, input bit pulse_done);
    int cyc;
    push_frame();
    sel_log.delete();
    done_pulses = 0;
    screen_end = 1'b1;
    @(posedge clock); #1;
    screen_end = 1'b0;
    check({tag, "_disp"}, {31'b0, disp_buf}, {31'b0, exp_disp});
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!frame_done && cyc < PC + 2000) begin
      @(posedge clock); #1;
      cyc++;
      screen_end = (pulse_clear && cyc == 100);
    end
    check({tag, "_cycles"}, cyc, frame_edges());
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    screen_end = pulse_done;
    @(posedge clock); #1;
    screen_end = 1'b0;
    @(posedge clock); #1;
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_disp"}, {31'b0, disp_buf}, {31'b0, exp_disp});
    check({tag, "_q_left"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_pulses, 1);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int b = 0; b < MB; b++) begin xs[b] = 10'd700; ys[b] = 9'd100; end
    reset = 1'b1;
    screen_end = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("rst_disp", {31'b0, disp_buf}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_data", {31'b0, wr_data}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_sel", boid_sel, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_overrun", overrun_count, 32'd0);
    mon_en = 1'b1;

    // Mixed slots: interior, off-screen, bottom-right corner, interior.
    xs[0] = 10'd10;  ys[0] = 9'd10;
    xs[1] = 10'd700; ys[1] = 9'd100;
    xs[2] = 10'd639; ys[2] = 9'd11;
    xs[3] = 10'd300; ys[3] = 9'd5;
    run_frame("f1", 1'b1, 1'b0, 1'b0);

    for (int b = 0; b < MB; b++) begin xs[b] = 10'd700; ys[b] = 9'd100; end
    run_frame("f2", 1'b0, 1'b0, 1'b0);
    check("f2_sel_count", sel_log.size(), MB);
    for (int i = 0; i < sel_log.size() && i < MB; i++) check("f2_sel_step", sel_log[i], i);

    for (int b = 0; b < MB; b++) begin xs[b] = 10'(20 * b + 5); ys[b] = 9'(2 * b + 1); end
    run_frame("f3", 1'b1, 1'b1, 1'b1);
    check("f3_overrun", overrun_count, 32'd2);

    run_frame("f4", 1'b0, 1'b0, 1'b0);
    check("f4_overrun", overrun_count, 32'd2);

    // Abort during the draw phase.
    mon_en = 1'b0;
    xs[0] = 10'd10; ys[0] = 9'd10;
    screen_end = 1'b1;
    @(posedge clock); #1;
    screen_end = 1'b0;
    cyc = 0;
    while (!(wr_en && wr_data) && cyc < PC + 100) begin @(posedge clock); #1; cyc++; end
    check("abort_draw_seen", {31'b0, wr_en & wr_data}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_wr_en", {31'b0, wr_en}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_disp", {31'b0, disp_buf}, 32'd0);
    repeat (10) @(posedge clock); #1;
    check("abort_quiet", {31'b0, wr_en | busy}, 32'd0);
    mon_en = 1'b1;
    run_frame("f5", 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
- Write side of the boid display path. The VGA controller only reads the 1-bit boid display memory; this block fills it.
- On each screen_end pulse it swaps the double-buffered display memory, then clears the new back buffer.
- It then walks every boid position slot, one per step, and writes a SPRITE_SIZE x SPRITE_SIZE square of 1s per boid into the back buffer.
- It sits between the BPU array (position source) and the display RAM write port.

Parameters:
- MAX_BOIDS, 4: number of boid slots scanned per frame.
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS): width of the boid index.
- VIDEO_WIDTH, 640: pixels per line.
- VIDEO_HEIGHT, 480: lines per frame.
- PIXEL_ADDRESS_WIDTH, 19: display RAM address width.
- SPRITE_SIZE, 2: side length of the drawn square, in pixels (1..8).

Ports:
- clock  in  1  system clock (50 MHz domain).
- reset  in  1  synchronous, active-high reset.
- screen_end  in  1  one-cycle pulse from the VGA controller at end of visible frame.
- boid_sel  out  BITS_FOR_BOIDS  index of the boid whose position is requested.
- boid_x  in  10  x position of the selected boid, valid one cycle after boid_sel changes.
- boid_y  in  9  y position of the selected boid, same timing as boid_x.
- wr_en  out  1  display RAM write enable.
- wr_buf  out  1  which buffer is written (always ~disp_buf).
- wr_addr  out  PIXEL_ADDRESS_WIDTH  write address.
- wr_data  out  1  write data: 0 during clear, 1 during draw.
- disp_buf  out  1  buffer the VGA controller must read.
- busy  out  1  high from the accepted screen_end until DONE.
- frame_done  out  1  one-cycle pulse when the back buffer is complete.
- overrun_count  out  8  saturating count of screen_end pulses ignored while busy.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, disp_buf=0, wr_en=0, wr_data=0, wr_addr=0, boid_sel=0, busy=0, frame_done=0, overrun_count=0. Reset mid-frame aborts immediately; no further writes occur.
- All outputs are registered.

State machine:
- IDLE: on screen_end, toggle disp_buf, set busy=1, clear pixel counter, go to CLEAR.
- CLEAR: wr_en=1, wr_data=0, wr_addr=0..PIXEL_COUNT-1, one address per cycle. After address PIXEL_COUNT-1, set boid_sel=0 and go to FETCH.
- FETCH: wr_en=0. Wait exactly one cycle for read latency, then go to LATCH.
- LATCH: register boid_x/boid_y as base (bx, by).
  - If bx>=VIDEO_WIDTH or by>=VIDEO_HEIGHT, the slot is invalid: skip to NEXT.
  - Otherwise dx=dy=0; go to DRAW.
- DRAW: one pixel per cycle, wr_en=1, wr_data=1, addr=(py<<9)+(py<<7)+px, with dx as the inner loop.
  - Pixels are visited row-major: dx 0..SPRITE_SIZE-1, then dy++.
  - After (SPRITE_SIZE-1, SPRITE_SIZE-1), go to NEXT.
- NEXT: wr_en=0.
  - If boid_sel==MAX_BOIDS-1, go to DONE.
  - Otherwise boid_sel++ and go to FETCH.
- DONE: frame_done=1 for one cycle, busy=0, boid_sel=0, then IDLE.

Timing and boundary rules:
- Cycles per frame = PIXEL_COUNT + MAX_BOIDS*(3 + SPRITE_SIZE^2) + 1 for valid boids; this must fit inside one frame period.
- screen_end while busy: ignored, overrun_count++ saturating at 255, disp_buf unchanged.
- screen_end in the same cycle DONE is reached: DONE completes, the pulse counts as an overrun and does not start a frame.
- Address arithmetic: px/py are computed at 10/9 bits; the address sum is 19 bits. No multiplier; shifts only.

Optional Feature:
BOID_CLIP_EN
- Defined: a sprite pixel with px>=VIDEO_WIDTH or py>=VIDEO_HEIGHT is suppressed (wr_en=0 that cycle). Cycle count is unchanged.
- Undefined: edge pixels wrap. px=bx+dx-VIDEO_WIDTH when bx+dx>=VIDEO_WIDTH; py wraps the same way using VIDEO_HEIGHT. wr_en stays 1.

Test Plan:
- Reset then screen_end pulse -> disp_buf 0->1, busy=1. wr_en=1 for 307200 cycles with wr_data=0 and wr_addr 0..307199, ending at 307199.
- Boid 0 at (10,10), SPRITE_SIZE=2 -> after clear, writes with data 1 at addresses 6410, 6411, 7050, 7051, in that order.
- All boids at (700,100) -> no draw writes, boid_sel steps 0..3, frame_done pulses once, busy drops.
- screen_end pulsed during CLEAR -> overrun_count=1, disp_buf unchanged, frame completes normally. A second pulse after DONE toggles disp_buf.
- Boid at (639,479), with and without BOID_CLIP_EN:
  - Defined: only address 307199 is written.
  - Undefined: writes 307199, 306560, 639, 0.
- reset asserted mid-DRAW -> next cycle wr_en=0, busy=0, disp_buf=0, state IDLE. A new screen_end restarts from CLEAR.
